// File: rtl/perf_display.sv
// perf_display: periodic sampler that turns an unsigned value into display
// digits in hex or decimal form, with overflow saturation and optional
// leading-zero blanking.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   rst      - asynchronous, active-low reset
//   value    - unsigned quantity to display (DATA_W bits)
//   mode     - 0 = hex, 1 = decimal; sampled together with value
//   blank_lz - 1 = blank leading zero digits; sampled together with value
//   hold     - 1 = freeze the display (refresh ticks are skipped)
//   digits   - DIGITS 4-bit digits, digit 0 in bits [3:0]
//   blank    - bit i set means digit i is shown dark
//   ovf      - last sampled value did not fit in DIGITS digits
//   busy     - a capture is being processed
//   update   - one-cycle pulse when new display contents take effect
module perf_display #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned REFRESH_LOG2 = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic                  hold,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf,
  output logic                  busy,
  output logic                  update
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, HEX, CONV, DONE} state_t;

  state_t                  state, state_nxt;
  logic [REFRESH_LOG2-1:0] refresh_cnt;
  logic                    tick;
  logic                    capture;

  logic [DATA_W-1:0]       shift_q;
  logic                    mode_q;
  logic                    blz_q;
  logic [BW-1:0]           bcd_q;
  logic [BW-1:0]           bcd_adj;
  logic                    bcd_ovf_q;
  logic [CW-1:0]           bit_cnt;

  logic [31:0]             val_ext;
  logic [BW-1:0]           hex_digits;
  logic                    hex_ovf;
  logic [BW-1:0]           disp_digits;
  logic [DIGITS-1:0]       disp_blank;
  logic                    disp_ovf;
  logic                    zero_run;

  assign tick    = (refresh_cnt == '0);
  assign capture = (state == IDLE) && tick && !hold;
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = mode ? CONV : HEX;
      HEX:     state_nxt = IDLE;
      CONV:    if (bit_cnt == CW'(DATA_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Hex view: the captured value is still unshifted while in HEX
  assign val_ext    = 32'(shift_q);
  assign hex_digits = val_ext[BW-1:0];
  assign hex_ovf    = |(val_ext >> BW);

  // Final display image, including overflow saturation and blanking
  always_comb begin
    disp_ovf    = mode_q ? bcd_ovf_q : hex_ovf;
    disp_digits = mode_q ? bcd_q : hex_digits;
    if (disp_ovf) disp_digits = mode_q ? {DIGITS{4'h9}} : '1;
    disp_blank = '0;
    zero_run   = 1'b1;
    // Walk from the top digit down; digit 0 is never blanked
    for (int unsigned j = 0; j + 1 < DIGITS; j++) begin
      zero_run = zero_run & (disp_digits[4*(DIGITS-1-j) +: 4] == 4'h0);
      disp_blank[DIGITS-1-j] = blz_q & ~disp_ovf & zero_run;
    end
  end

  // Datapath and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      shift_q     <= '0;
      mode_q      <= 1'b0;
      blz_q       <= 1'b0;
      bcd_q       <= '0;
      bcd_ovf_q   <= 1'b0;
      bit_cnt     <= '0;
      digits      <= '1;
      blank       <= '0;
      ovf         <= 1'b0;
      update      <= 1'b0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_LOG2'(1);
      update      <= 1'b0;
      if (capture) begin
        shift_q   <= value;
        mode_q    <= mode;
        blz_q     <= blank_lz;
        bcd_q     <= '0;
        bcd_ovf_q <= 1'b0;
        bit_cnt   <= '0;
      end
      if (state == CONV) begin
        shift_q   <= shift_q << 1;
        bcd_q     <= {bcd_adj[BW-2:0], shift_q[DATA_W-1]};
        bcd_ovf_q <= bcd_ovf_q | bcd_adj[BW-1];
        bit_cnt   <= bit_cnt + CW'(1);
      end
      if (state == HEX || state == DONE) begin
        digits <= disp_digits;
        blank  <= disp_blank;
        ovf    <= disp_ovf;
        update <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_perf_display.sv
// Scoreboard bench for perf_display (DATA_W=32, DIGITS=6, REFRESH_LOG2=6).
module tb_perf_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        mode;
  logic        blank_lz;
  logic        hold;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic        ovf;
  logic        busy;
  logic        update;

  perf_display #(
    .DATA_W       (32),
    .DIGITS       (6),
    .REFRESH_LOG2 (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .mode     (mode),
    .blank_lz (blank_lz),
    .hold     (hold),
    .digits   (digits),
    .blank    (blank),
    .ovf      (ovf),
    .busy     (busy),
    .update   (update)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic [5:0]  b;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endtask

  // Monitor: every update pulse consumes one expected display image
  always @(negedge clk) begin
    exp_t e;
    if (update === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_update: got digits %h blank %b ovf %b expected no update",
                 digits, blank, ovf);
      end else begin
        e = exp_q.pop_front();
        check("upd_digits", 32'(digits), 32'(e.d));
        check("upd_blank",  32'(blank),  32'(e.b));
        check("upd_ovf",    32'(ovf),    32'(e.o));
      end
    end
  end

  // Issue one capture, then scramble the inputs while busy.
  task automatic do_capture(input logic [31:0] v, input logic m, input logic blz,
                            input logic [23:0] ed, input logic [5:0] eb, input logic eo,
                            input int exp_rise);
    int waited;
    int n;
    value    = v;
    mode     = m;
    blank_lz = blz;
    exp_q.push_back('{ed, eb, eo});
    hold     = 1'b0;
    waited   = 0;
    while (busy !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    hold     = 1'b1;
    value    = ~v;
    mode     = ~m;
    blank_lz = ~blz;
    check("capture_started", 32'(busy), 32'd1);
    if (exp_rise != 0) check("first_tick_wait", 32'(waited), 32'(exp_rise));
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), m ? 32'd33 : 32'd1);
  endtask

  initial begin
    int n;
    int w;
    rst      = 1'b0;
    hold     = 1'b1;
    value    = '0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(digits), 32'h00FFFFFF);
    check("rst_blank",  32'(blank),  32'd0);
    check("rst_flags",  32'({ovf, busy, update}), 32'd0);

    // Release and capture on the very first tick
    rst = 1'b1;
    do_capture(32'h00ABCDEF, 1'b0, 1'b0, 24'hABCDEF, 6'b000000, 1'b0, 1);
    do_capture(32'd123456,   1'b1, 1'b0, 24'h123456, 6'b000000, 1'b0, 0);
    do_capture(32'd1000000,  1'b1, 1'b0, 24'h999999, 6'b000000, 1'b1, 0);
    do_capture(32'h01000000, 1'b0, 1'b0, 24'hFFFFFF, 6'b000000, 1'b1, 0);
    do_capture(32'd42,       1'b1, 1'b1, 24'h000042, 6'b111100, 1'b0, 0);
    do_capture(32'd0,        1'b1, 1'b1, 24'h000000, 6'b111110, 1'b0, 0);
    do_capture(32'h00000A05, 1'b0, 1'b1, 24'h000A05, 6'b111000, 1'b0, 0);

    // Hold across two ticks: nothing starts, display stays put
    hold  = 1'b1;
    value = 32'd7;
    mode  = 1'b0;
    n = 0;
    repeat (140) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    check("hold_busy", 32'(n), 32'd0);
    check("hold_digits", 32'(digits), 32'h00000A05);
    check("hold_blank",  32'(blank),  32'b111000);

    // Reset ten cycles into a decimal conversion
    value    = 32'd123456;
    mode     = 1'b1;
    blank_lz = 1'b0;
    hold     = 1'b0;
    w = 0;
    while (busy !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    hold = 1'b1;
    check("abort_started", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_digits", 32'(digits), 32'h00FFFFFF);
    check("abort_blank",  32'(blank),  32'd0);
    check("abort_flags",  32'({ovf, busy, update}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    do_capture(32'd999,    1'b1, 1'b0, 24'h000999, 6'b000000, 1'b0, 1);
    do_capture(32'd999999, 1'b1, 1'b1, 24'h999999, 6'b000000, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("pending_updates", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
